// File: rtl/mem_readback_scanner.sv
// Read-side RAM scan engine: folds each word into a rotating checksum.
// Optional first-mismatch capture is built when SCAN_FIRST_ERR_EN is defined.
module mem_readback_scanner #(
    parameter int WID_MEM    = 4,
    parameter int DEPTH_MEM  = 8192,
    parameter int SCAN_DEPTH = DEPTH_MEM - 1,
    parameter int SEED       = 0,
    parameter int CNT_W      = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic [31:0]        raddr,
    output logic [31:0]        waddr,
    output logic [WID_MEM-1:0] din,
    input  logic [WID_MEM-1:0] mem_dout,
    output logic               busy,
    output logic               done,
    output logic [15:0]        checksum,
    output logic [CNT_W-1:0]   err_count,
    output logic [31:0]        first_err_addr,
    output logic               first_err_valid
);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DRAIN,
        DONE
    } state_t;

    localparam logic [31:0]        LAST    = 32'(SCAN_DEPTH - 1);
    localparam logic [31:0]        SINK    = 32'(DEPTH_MEM - 1);
    localparam logic [WID_MEM-1:0] SEED_W  = WID_MEM'(SEED);
    localparam logic [CNT_W-1:0]   CNT_MAX = '1;

    state_t               state;
    state_t               state_nx;
    logic                 accept;
    logic                 last_issue;
    logic                 vld_d;
    logic [WID_MEM-1:0]   addr_lo;
    logic [15:0]          d16;
    logic                 mismatch;

    // The RAM writes every clock, so the write port is parked on the sink word.
    assign waddr = SINK;
    assign din   = '0;

    assign accept     = start && (state == IDLE || state == DONE);
    assign last_issue = (state == SCAN) && (raddr == LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = SCAN;
            SCAN:    if (last_issue) state_nx = DRAIN;
            DRAIN:   state_nx = DONE;
            DONE:    if (start) state_nx = SCAN;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (state)
            SCAN, DRAIN: busy = 1'b1;
            DONE:        done = 1'b1;
            default:     ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            raddr <= '0;
        else if (state == SCAN && !last_issue)
            raddr <= raddr + 32'd1;
        else
            raddr <= '0;
    end

    // Tag the one-cycle RAM latency with the issuing address.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_d   <= 1'b0;
            addr_lo <= '0;
        end else begin
            vld_d   <= (state == SCAN);
            addr_lo <= raddr[WID_MEM-1:0];
        end
    end

    always_comb begin
        d16 = '0;
        d16[WID_MEM-1:0] = mem_dout;
    end

    assign mismatch = mem_dout != (addr_lo ^ SEED_W);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            checksum  <= '0;
            err_count <= '0;
        end else if (accept) begin
            checksum  <= '0;
            err_count <= '0;
        end else if (vld_d) begin
            checksum <= {checksum[14:0], checksum[15]} ^ d16;
            if (mismatch && err_count != CNT_MAX)
                err_count <= err_count + 1'b1;
        end
    end

`ifdef SCAN_FIRST_ERR_EN
    logic [31:0] addr_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) addr_d <= '0;
        else        addr_d <= raddr;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            first_err_addr  <= 32'hFFFF_FFFF;
            first_err_valid <= 1'b0;
        end else if (accept) begin
            first_err_addr  <= 32'hFFFF_FFFF;
            first_err_valid <= 1'b0;
        end else if (vld_d && mismatch && !first_err_valid) begin
            first_err_addr  <= addr_d;
            first_err_valid <= 1'b1;
        end
    end
`else
    assign first_err_addr  = 32'hFFFF_FFFF;
    assign first_err_valid = 1'b0;
`endif

endmodule

// File: tb/tb_mem_readback_scanner.sv
// Scoreboard bench for mem_readback_scanner on a 16-word RAM model.
// A second instance with a 2-bit error counter checks saturation.
module tb_mem_readback_scanner;

    localparam int N  = 15;
    localparam int DM = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] raddr, waddr, fe_addr;
    logic [31:0] raddr2, waddr2, fe_addr2;
    logic [3:0]  din, din2, dout, dout2;
    logic        busy, done, fev;
    logic        busy2, done2, fev2;
    logic [15:0] cs, cs2;
    logic [15:0] err;
    logic [1:0]  err2;

    logic [3:0]  mem  [DM];
    logic [3:0]  mem2 [DM];
    logic [3:0]  pre  [DM];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic done_q = 1'b0;

    typedef struct {
        int          e0;
        logic [15:0] cs;
        int          err;
        logic [31:0] fa;
        logic        fv;
    } exp_t;

    exp_t sb[$];

    mem_readback_scanner #(
        .WID_MEM(4), .DEPTH_MEM(DM), .SCAN_DEPTH(N),
        .SEED(0), .CNT_W(16)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .raddr(raddr), .waddr(waddr), .din(din),
        .mem_dout(dout), .busy(busy), .done(done),
        .checksum(cs), .err_count(err),
        .first_err_addr(fe_addr), .first_err_valid(fev)
    );

    mem_readback_scanner #(
        .WID_MEM(4), .DEPTH_MEM(DM), .SCAN_DEPTH(N),
        .SEED(0), .CNT_W(2)
    ) dut2 (
        .clk(clk), .reset(reset), .start(start),
        .raddr(raddr2), .waddr(waddr2), .din(din2),
        .mem_dout(dout2), .busy(busy2), .done(done2),
        .checksum(cs2), .err_count(err2),
        .first_err_addr(fe_addr2), .first_err_valid(fev2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Block RAM model: registered read, unconditional write.
    always @(posedge clk) begin
        dout  <= mem[raddr[3:0]];
        dout2 <= mem2[raddr2[3:0]];
        mem[waddr[3:0]]   <= din;
        mem2[waddr2[3:0]] <= din2;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: walk the image, rotate-left-and-xor, count mismatches.
    function automatic exp_t model(input int e0);
        exp_t e;
        e.e0  = e0;
        e.cs  = 16'h0;
        e.err = 0;
        e.fa  = 32'hFFFF_FFFF;
        e.fv  = 1'b0;
        for (int a = 0; a < N; a++) begin
            e.cs = {e.cs[14:0], e.cs[15]} ^ {12'h0, pre[a]};
            if (pre[a] != 4'(a)) begin
                e.err++;
                if (!e.fv) begin
                    e.fa = a;
                    e.fv = 1'b1;
                end
            end
        end
`ifndef SCAN_FIRST_ERR_EN
        e.fa = 32'hFFFF_FFFF;
        e.fv = 1'b0;
`endif
        return e;
    endfunction

    task automatic kick();
        for (int a = 0; a < N; a++) begin
            mem[a]  = pre[a];
            mem2[a] = pre[a];
        end
        @(negedge clk);
        sb.push_back(model(cyc + 1));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int t = 0;
        while (sb.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL timeout: %0d scans pending expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic fill_pattern();
        for (int a = 0; a < DM; a++) pre[a] = 4'(a);
    endtask

    task automatic fill_random();
        for (int a = 0; a < DM; a++)
            pre[a] = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'(a);
    endtask

    always @(negedge clk) begin
        if (reset) begin
            chk("waddr", waddr, 32'd15);
            chk("din", {28'h0, din}, 32'h0);
            if (sb.size() != 0) begin
                int k;
                k = cyc - sb[0].e0 + 1;
                if (k >= 1 && k <= N + 1)
                    chk("busy_done_in_scan", {busy, done}, 2'b10);
                if (k == 1)
                    chk("cleared", {cs, err}, 32'h0);
                if (done && !done_q) begin
                    exp_t e;
                    int e2;
                    e  = sb.pop_front();
                    e2 = (e.err > 3) ? 3 : e.err;
                    chk("done_latency", k, N + 2);
                    chk("busy_at_done", {31'h0, busy}, 32'h0);
                    chk("checksum", {16'h0, cs}, {16'h0, e.cs});
                    chk("err_count", {16'h0, err}, e.err);
                    chk("err_count_sat", {30'h0, err2}, e2);
                    chk("checksum2", {16'h0, cs2}, {16'h0, e.cs});
                    chk("first_err_addr", fe_addr, e.fa);
                    chk("first_err_valid", {31'h0, fev}, {31'h0, e.fv});
                end
            end else if (done && !done_q) begin
                errors++;
                $display("FAIL unexpected_done: got 1 expected 0");
            end
        end
        done_q = done;
    end

    initial begin
        reset = 1'b0;
        start = 1'b0;
        for (int a = 0; a < DM; a++) begin
            mem[a]  = 4'h0;
            mem2[a] = 4'h0;
        end
        repeat (3) @(negedge clk);
        #1;
        chk("rst_raddr", raddr, 32'h0);
        chk("rst_waddr", waddr, 32'd15);
        chk("rst_flags", {busy, done, fev}, 3'b000);
        chk("rst_cs_err", {cs, err}, 32'h0);
        chk("rst_fe_addr", fe_addr, 32'hFFFF_FFFF);
        @(negedge clk);
        reset = 1'b1;

        fill_pattern();
        kick();
        wait_done();

        for (int a = 0; a < DM; a++) pre[a] = 4'h0;
        kick();
        wait_done();

        fill_pattern();
        pre[5] = 4'hA;
        kick();
        wait_done();

        for (int r = 0; r < 6; r++) begin
            fill_random();
            repeat ($urandom_range(0, 3)) @(negedge clk);
            kick();
            wait_done();
        end

        // Start mid-scan must be ignored.
        fill_random();
        kick();
        repeat (4) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();

        // Start straight out of DONE.
        fill_random();
        kick();
        wait_done();

        // Abort mid-scan with reset.
        fill_random();
        pre[2] = ~4'd2;
        kick();
        repeat (6) @(negedge clk);
        reset = 1'b0;
        #1;
        sb.delete();
        chk("abort_raddr", raddr, 32'h0);
        chk("abort_flags", {busy, done, fev}, 3'b000);
        chk("abort_cs_err", {cs, err}, 32'h0);
        chk("abort_fe_addr", fe_addr, 32'hFFFF_FFFF);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        fill_pattern();
        kick();
        wait_done();

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
